// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter / branch-resolution stage:
// field widths, condition codes, FSM state and next-PC source encoding.
package pc_ctrl_pkg;

    localparam int unsigned PC_W_DEF = 16;
    localparam int unsigned CC_W     = 3;
    localparam int unsigned IMM9_W   = 9;
    localparam int unsigned IMM12_W  = 12;

    typedef logic [CC_W-1:0] cc_t;

    localparam cc_t CC_NE     = 3'b000;
    localparam cc_t CC_EQ     = 3'b001;
    localparam cc_t CC_GT     = 3'b010;
    localparam cc_t CC_LT     = 3'b011;
    localparam cc_t CC_GTE    = 3'b100;
    localparam cc_t CC_LTE    = 3'b101;
    localparam cc_t CC_OVF    = 3'b110;
    localparam cc_t CC_UNCOND = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Source of the next PC; HOLD covers stall and HALT, HLT covers the halting commit.
    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_HLT  = 3'd2,
        SEL_JR   = 3'd3,
        SEL_JAL  = 3'd4,
        SEL_BR   = 3'd5
    } sel_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Decode/fetch-facing signal bundle of the PC stage. The decode side (master)
// drives instruction fields and flags; the PC stage (slave) drives fetch state.
interface pc_ctrl_if
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) ();

    logic               stall;
    logic               br;
    logic               jal;
    logic               jr;
    logic               hlt;
    logic [CC_W-1:0]    ccc;
    logic [IMM9_W-1:0]  imm9;
    logic [IMM12_W-1:0] imm12;
    logic [PC_W-1:0]    jr_tgt;
    logic               N;
    logic               Z;
    logic               V;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               taken;
    logic               halted;
    logic [PC_W-1:0]    instr_cnt;

    modport master (
        output stall, br, jal, jr, hlt, ccc, imm9, imm12, jr_tgt, N, Z, V,
        input  pc, pc_plus1, taken, halted, instr_cnt
    );

    modport slave (
        input  stall, br, jal, jr, hlt, ccc, imm9, imm12, jr_tgt, N, Z, V,
        output pc, pc_plus1, taken, halted, instr_cnt
    );

endinterface

// File: rtl/pc_ctrl_br_cond.sv
// Combinational branch-condition evaluator: maps a 3-bit condition code and
// the ALU N/Z/V flags to a single condition-true bit.
module pc_ctrl_br_cond
    import pc_ctrl_pkg::*;
(
    input  cc_t  ccc,
    input  logic n,
    input  logic z,
    input  logic v,
    output logic cond_true
);

    always_comb begin
        cond_true = 1'b0;
        unique case (ccc)
            CC_NE:     cond_true = !z;
            CC_EQ:     cond_true = z;
            CC_GT:     cond_true = !z && !n;
            CC_LT:     cond_true = n;
            CC_GTE:    cond_true = z || !n;
            CC_LTE:    cond_true = n || z;
            CC_OVF:    cond_true = v;
            CC_UNCOND: cond_true = 1'b1;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter with branch resolution, RUN/HALT control and a saturating
// committed-instruction counter. Redirects take effect at the next clock edge.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    pc_ctrl_if.slave bus
);

    state_t          state;
    sel_t            sel;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] cnt_q;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] jal_tgt;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] cnt_next;
    logic            commit;
    logic            cond_true;
    logic            taken;

    pc_ctrl_br_cond u_br_cond (
        .ccc       (bus.ccc),
        .n         (bus.N),
        .z         (bus.Z),
        .v         (bus.V),
        .cond_true (cond_true)
    );

    // Targets are relative to pc+1; all adds wrap modulo 2^PC_W.
    always_comb begin
        pc_plus1 = pc_q + PC_W'(1);
        br_tgt   = pc_plus1 + PC_W'(signed'(bus.imm9));
        jal_tgt  = pc_plus1 + PC_W'(signed'(bus.imm12));
        cnt_next = (cnt_q == {PC_W{1'b1}}) ? cnt_q : cnt_q + PC_W'(1);
        commit   = (state == ST_RUN) && !bus.stall;
    end

    // Priority select; decode guarantees one-hot, the order only resolves overlap.
    always_comb begin
        sel = SEL_HOLD;
        if (commit) begin
            if (bus.hlt)                  sel = SEL_HLT;
            else if (bus.jr)              sel = SEL_JR;
            else if (bus.jal)             sel = SEL_JAL;
            else if (bus.br && cond_true) sel = SEL_BR;
            else                          sel = SEL_SEQ;
        end
    end

    always_comb begin
        pc_next = pc_q;
        taken   = 1'b0;
        unique case (sel)
            SEL_SEQ: pc_next = pc_plus1;
            SEL_JR: begin
                pc_next = bus.jr_tgt;
                taken   = 1'b1;
            end
            SEL_JAL: begin
                pc_next = jal_tgt;
                taken   = 1'b1;
            end
            SEL_BR: begin
                pc_next = br_tgt;
                taken   = 1'b1;
            end
            default: pc_next = pc_q;
        endcase
    end

    // HLT commits (counts, PC stays on the HLT address), then freezes until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else if (commit) begin
            pc_q  <= pc_next;
            cnt_q <= cnt_next;
            if (sel == SEL_HLT) begin
                state <= ST_HALT;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_plus1;
    assign bus.taken     = taken;
    assign bus.halted    = (state == ST_HALT);
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl: sequential flow, branches, JAL/JR,
// full condition sweep, stall/halt/reset interaction, PC wrap, counter saturation.
module tb_pc_ctrl;

    localparam int unsigned PC_W = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [PC_W-1:0] exp_pc;
    logic [2:0]      flg;
    logic            exp_t;

    pc_ctrl_if #(.PC_W(PC_W)) bus ();

    pc_ctrl #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.stall  = 1'b0;
        bus.br     = 1'b0;
        bus.jal    = 1'b0;
        bus.jr     = 1'b0;
        bus.hlt    = 1'b0;
        bus.ccc    = 3'b000;
        bus.imm9   = '0;
        bus.imm12  = '0;
        bus.jr_tgt = '0;
        bus.N      = 1'b0;
        bus.Z      = 1'b0;
        bus.V      = 1'b0;
    endtask

    task automatic jump_to(input logic [PC_W-1:0] tgt);
        idle();
        bus.jr     = 1'b1;
        bus.jr_tgt = tgt;
        step();
        idle();
    endtask

    // Condition table written from the ISA definition, bit index = condition code.
    function automatic logic ref_cond(input int cc, input logic n, input logic z, input logic v);
        logic [7:0] t;
        t = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
        return t[cc];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_cnt", 32'(bus.instr_cnt), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        rst = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            check("idle_taken", 32'(bus.taken), 32'h0);
            step();
            check("idle_pc", 32'(bus.pc), 32'(i));
        end
        check("idle_cnt", 32'(bus.instr_cnt), 32'd3);
        check("idle_halted", 32'(bus.halted), 32'h0);

        // EQ branch taken with negative offset, then not taken
        jump_to(16'h0010);
        bus.br = 1'b1; bus.ccc = 3'b001; bus.Z = 1'b1; bus.imm9 = 9'h1FD;
        #1 check("beq_taken", 32'(bus.taken), 32'h1);
        check("beq_plus1", 32'(bus.pc_plus1), 32'h0011);
        step();
        check("beq_pc", 32'(bus.pc), 32'h000E);
        jump_to(16'h0010);
        bus.br = 1'b1; bus.ccc = 3'b001; bus.Z = 1'b0; bus.imm9 = 9'h1FD;
        #1 check("beq_nt_taken", 32'(bus.taken), 32'h0);
        step();
        check("beq_nt_pc", 32'(bus.pc), 32'h0011);

        // JAL then JR
        jump_to(16'h0020);
        bus.jal = 1'b1; bus.imm12 = 12'h100;
        #1 check("jal_plus1", 32'(bus.pc_plus1), 32'h0021);
        check("jal_taken", 32'(bus.taken), 32'h1);
        step();
        check("jal_pc", 32'(bus.pc), 32'h0121);
        idle();
        bus.jr = 1'b1; bus.jr_tgt = 16'h1234;
        #1 check("jr_taken", 32'(bus.taken), 32'h1);
        step();
        check("jr_pc", 32'(bus.pc), 32'h1234);
        check("jr_cnt", 32'(bus.instr_cnt), 32'd10);

        // All condition codes against all flag combinations
        idle();
        exp_pc = 16'h1234;
        for (int cc = 0; cc < 8; cc++) begin
            for (int f = 0; f < 8; f++) begin
                flg = 3'(f);
                exp_t = ref_cond(cc, flg[2], flg[1], flg[0]);
                bus.br = 1'b1; bus.ccc = 3'(cc); bus.imm9 = 9'h004;
                bus.N = flg[2]; bus.Z = flg[1]; bus.V = flg[0];
                #1 check($sformatf("sweep_taken_cc%0d_f%0d", cc, f), 32'(bus.taken), 32'(exp_t));
                step();
                exp_pc = exp_t ? exp_pc + 16'd5 : exp_pc + 16'd1;
                check($sformatf("sweep_pc_cc%0d_f%0d", cc, f), 32'(bus.pc), 32'(exp_pc));
            end
        end
        check("sweep_cnt", 32'(bus.instr_cnt), 32'd74);

        // Stall blocks a taken branch and HLT
        jump_to(16'h0030);
        bus.stall = 1'b1; bus.br = 1'b1; bus.ccc = 3'b111; bus.imm9 = 9'h004;
        #1 check("stall_br_taken", 32'(bus.taken), 32'h0);
        step();
        check("stall_br_pc", 32'(bus.pc), 32'h0030);
        idle();
        bus.stall = 1'b1; bus.hlt = 1'b1;
        step();
        check("stall_hlt_pc", 32'(bus.pc), 32'h0030);
        check("stall_hlt_halted", 32'(bus.halted), 32'h0);
        check("stall_hlt_cnt", 32'(bus.instr_cnt), 32'd75);
        bus.stall = 1'b0;
        #1 check("hlt_taken", 32'(bus.taken), 32'h0);
        step();
        check("hlt_halted", 32'(bus.halted), 32'h1);
        check("hlt_pc", 32'(bus.pc), 32'h0030);
        check("hlt_cnt", 32'(bus.instr_cnt), 32'd76);

        // HALT ignores everything but reset
        idle();
        bus.jr = 1'b1; bus.jr_tgt = 16'h0055; bus.br = 1'b1; bus.ccc = 3'b111;
        #1 check("halt_taken", 32'(bus.taken), 32'h0);
        step();
        check("halt_pc", 32'(bus.pc), 32'h0030);
        check("halt_plus1", 32'(bus.pc_plus1), 32'h0031);
        check("halt_cnt", 32'(bus.instr_cnt), 32'd76);
        bus.stall = 1'b1;
        step();
        check("halt_stall_halted", 32'(bus.halted), 32'h1);
        check("halt_stall_pc", 32'(bus.pc), 32'h0030);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_pc", 32'(bus.pc), 32'h0000);
        check("halt_rst_halted", 32'(bus.halted), 32'h0);
        check("halt_rst_cnt", 32'(bus.instr_cnt), 32'h0);

        // PC wraps from 0xFFFF to 0x0000
        jump_to(16'hFFFF);
        check("wrap_pre_pc", 32'(bus.pc), 32'hFFFF);
        check("wrap_plus1", 32'(bus.pc_plus1), 32'h0000);
        step();
        check("wrap_pc", 32'(bus.pc), 32'h0000);
        check("wrap_cnt", 32'(bus.instr_cnt), 32'd2);

        // Counter saturates at all-ones
        for (int k = 0; k < 65532; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("sat_fffe", 32'(bus.instr_cnt), 32'hFFFE);
        step();
        check("sat_ffff", 32'(bus.instr_cnt), 32'hFFFF);
        step();
        step();
        check("sat_hold", 32'(bus.instr_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Program-counter and branch-resolution stage that directly consumes the registered N/Z/V flags produced by the ALU.
- Holds the architectural PC and evaluates the 3-bit branch condition against the flags.
- Selects the next PC from: sequential, PC-relative branch, JAL, JR, or halt.
- Keeps a committed-instruction counter for bring-up and debug.
- Sits between decode/register-file (instruction fields, JR target) and instruction fetch (pc).

Parameters:
PC_W, 16, width of PC, targets and counter
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and counter this cycle; instruction not committed
br  in  1  current instruction is conditional branch
jal  in  1  current instruction is JAL
jr  in  1  current instruction is JR
hlt  in  1  current instruction is HLT
ccc  in  3  branch condition code
imm9  in  9  signed branch offset, in words
imm12  in  12  signed JAL offset, in words
jr_tgt  in  PC_W  JR target from register file
N  in  1  negative flag (registered, from ALU)
Z  in  1  zero flag (registered, from ALU)
V  in  1  overflow flag (registered, from ALU)
pc  out  PC_W  current fetch address (registered)
pc_plus1  out  PC_W  pc+1, combinational; JAL link value
taken  out  1  combinational; redirect (non-sequential next PC) this cycle
halted  out  1  registered; processor halted
instr_cnt  out  PC_W  committed-instruction count (registered)

Behaviour:
- Reset (rst=1 at clock edge, regardless of any other input):
  - pc=RESET_PC, state=RUN, halted=0, instr_cnt=0.
  - Reset has priority over stall, hlt and all branch inputs, and exits HALT.
- States:
  - RUN: normal operation.
  - HALT: pc, instr_cnt and halted frozen; taken=0; every input except rst is ignored.
- Commit condition: state==RUN and stall==0. With stall=1, pc and instr_cnt hold, taken=0, and hlt is not acted on.
- Word-addressed PC. All adds are modulo 2^PC_W: 0xFFFF+1 wraps to 0x0000, with no flag or error.
- Offsets are sign-extended to PC_W and added to pc_plus1, not to pc.
- Next-PC priority on a committed cycle. Decode guarantees one-hot; the priority only defines behaviour for illegal overlap.
  1. hlt: pc holds (stays at HLT address); state goes to HALT; halted=1 from the next cycle; taken=0.
  2. jr: pc = jr_tgt; taken=1.
  3. jal: pc = pc_plus1 + sext(imm12); taken=1.
  4. br with condition true: pc = pc_plus1 + sext(imm9); taken=1.
  5. Otherwise (including br with condition false): pc = pc_plus1; taken=0.
- Condition codes:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or N=0
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 UNCOND: always true
- Flags are sampled as presented in the same cycle. This block adds no latency; the redirect takes effect at the next edge.
- instr_cnt increments by 1 on every committed cycle, including the HLT commit. It saturates at all-ones and does not wrap.
- pc_plus1 is always pc+1, even in HALT.

Decomposition:
- Shared package:
  - condition-code constants CC_NE..CC_UNCOND (3'b000..3'b111)
  - state encoding RUN/HALT
  - PC_W default
- One natural sub-module: br_cond, a purely combinational evaluator (ccc, N, Z, V -> cond_true). It is reused by the verification model and is unit-tested standalone.

Test Plan:
- Reset then 3 idle cycles, no control inputs -> pc 0x0000,0x0001,0x0002,0x0003; instr_cnt=3; halted=0.
- pc=0x0010, br=1, ccc=001, Z=1, imm9=0x1FD (-3) -> taken=1, next pc=0x000E. Repeat with Z=0 -> taken=0, next pc=0x0011.
- pc=0x0020, jal=1, imm12=0x100 -> pc_plus1=0x0021, next pc=0x0121. Then jr=1, jr_tgt=0x1234 -> next pc=0x1234.
- Sweep all 8 ccc values against all 8 N/Z/V combinations with imm9=0x004 -> taken matches the condition table; target = pc+5 when taken.
- pc=0x0030, hlt=1 with stall=1 -> pc holds 0x0030, halted=0.
  - Drop stall -> halted=1 next cycle, pc stays 0x0030.
  - Subsequent jr/br/stall inputs have no effect.
  - rst=1 -> pc=0x0000, halted=0.
- Force pc=0xFFFF via jr_tgt, then idle -> pc=0x0000. Preload instr_cnt near 0xFFFF (long run) -> count saturates at 0xFFFF.
